// File: rtl/x2050_m_byte_reader_pkg.sv
// x2050_m_byte_reader_pkg: reader state encoding, byte-index constants and parity helper
// shared by the M register byte reader (X2050_MRD_PARITY_EN enables parity support).
package x2050_m_byte_reader_pkg;
    localparam int LEN_W_DEF = 8;
    localparam logic [1:0] MB_B0 = 2'd0;
    localparam logic [1:0] MB_B1 = 2'd1;
    localparam logic [1:0] MB_B2 = 2'd2;
    localparam logic [1:0] MB_B3 = 2'd3;
    typedef enum logic [1:0] {MRD_IDLE, MRD_WREQ, MRD_SEND} mrd_state_t;
    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/x2050_m_byte_reader_if.sv
// x2050_m_byte_reader_if: storage-word and byte-stream signals of the M register byte reader;
// X2050_MRD_PARITY_EN adds m_par, byte_par and perr.
interface x2050_m_byte_reader_if
    import x2050_m_byte_reader_pkg::*;
#(parameter int LEN_W = LEN_W_DEF);
    logic             start;
    logic [1:0]       mb;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             word_vld;
    logic [31:0]      m_reg;
    logic             word_req;
    logic [7:0]       rd_byte;
    logic             byte_vld;
    logic             byte_rdy;
    logic             busy;
    logic             done;
`ifdef X2050_MRD_PARITY_EN
    logic [3:0]       m_par;
    logic             byte_par;
    logic             perr;
    modport master (output start, mb, len, abort, word_vld, m_reg, byte_rdy, m_par,
                    input word_req, rd_byte, byte_vld, busy, done, byte_par, perr);
    modport slave  (input start, mb, len, abort, word_vld, m_reg, byte_rdy, m_par,
                    output word_req, rd_byte, byte_vld, busy, done, byte_par, perr);
`else
    modport master (output start, mb, len, abort, word_vld, m_reg, byte_rdy,
                    input word_req, rd_byte, byte_vld, busy, done);
    modport slave  (input start, mb, len, abort, word_vld, m_reg, byte_rdy,
                    output word_req, rd_byte, byte_vld, busy, done);
`endif
endinterface

// File: rtl/x2050_m_byte_reader_bytesel.sv
// x2050_mrd_bytesel: 4:1 byte select from a storage word (byte 0 in [31:24]);
// odd parity output only with X2050_MRD_PARITY_EN.
module x2050_mrd_bytesel
    import x2050_m_byte_reader_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  sel,
`ifdef X2050_MRD_PARITY_EN
    output logic        par,
`endif
    output logic [7:0]  sel_byte
);
    always_comb begin
        sel_byte = sel == MB_B0 ? word[31:24] :
                   sel == MB_B1 ? word[23:16] :
                   sel == MB_B2 ? word[15:8]  : word[7:0];
    end
`ifdef X2050_MRD_PARITY_EN
    assign par = odd_par(sel_byte);
`endif
endmodule

// File: rtl/x2050_m_byte_reader.sv
// x2050_m_byte_reader: unloads bytes from M register words starting at an MB pointer,
// requesting a new word at each boundary; X2050_MRD_PARITY_EN adds byte parity and checking.
module x2050_m_byte_reader
    import x2050_m_byte_reader_pkg::*;
#(parameter int LEN_W = LEN_W_DEF)
(
    input logic clk,
    input logic rst_n,
    x2050_m_byte_reader_if.slave bus
);
    mrd_state_t       state, state_n;
    logic [1:0]       mb;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      word;
    logic             done;
    logic             load, hs, last;
    logic [7:0]       sel_byte;

    // abort outranks both the word strobe and the byte handshake
    always_comb begin
        load = state == MRD_WREQ && bus.word_vld && !bus.abort;
        hs = state == MRD_SEND && bus.byte_rdy && !bus.abort;
        last = cnt == '0;
        state_n = state;
        if (state == MRD_IDLE)
            state_n = bus.start ? MRD_WREQ : MRD_IDLE;
        else if (bus.abort)
            state_n = MRD_IDLE;
        else if (load)
            state_n = MRD_SEND;
        else if (hs)
            state_n = last ? MRD_IDLE : mb == MB_B3 ? MRD_WREQ : MRD_SEND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= MRD_IDLE;
        else
            state <= state_n;
    end

`ifdef X2050_MRD_PARITY_EN
    logic perr, perr_hit, sel_par;
    // only bytes that will actually be sent from this word are checked
    always_comb begin
        perr_hit = 1'b0;
        for (int k = 0; k < 4; k++)
            if (k >= int'(mb) && k - int'(mb) <= int'(cnt) &&
                bus.m_par[3-k] != odd_par(bus.m_reg[8*(3-k) +: 8]))
                perr_hit = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb <= MB_B0;
            cnt <= '0;
            word <= '0;
            done <= 1'b0;
`ifdef X2050_MRD_PARITY_EN
            perr <= 1'b0;
`endif
        end else begin
            done <= state != MRD_IDLE && (bus.abort || (hs && last));
            if (state == MRD_IDLE && bus.start) begin
                mb <= bus.mb;
                cnt <= bus.len;
`ifdef X2050_MRD_PARITY_EN
                perr <= 1'b0;
`endif
            end
            if (load) begin
                word <= bus.m_reg;
`ifdef X2050_MRD_PARITY_EN
                perr <= perr | perr_hit;
`endif
            end
            if (hs && !last) begin
                cnt <= cnt - 1'b1;
                mb <= mb + 1'b1;
            end
        end
    end

    x2050_mrd_bytesel u_sel (
        .word(word),
        .sel(mb),
`ifdef X2050_MRD_PARITY_EN
        .par(sel_par),
`endif
        .sel_byte(sel_byte)
    );

    assign bus.rd_byte = sel_byte;
    assign bus.word_req = state == MRD_WREQ;
    assign bus.byte_vld = state == MRD_SEND;
    assign bus.busy = state != MRD_IDLE;
    assign bus.done = done;
`ifdef X2050_MRD_PARITY_EN
    assign bus.byte_par = bus.byte_vld & sel_par;
    assign bus.perr = perr;
`endif
endmodule

// File: tb/tb_x2050_m_byte_reader.sv
// tb_x2050_m_byte_reader: randomized bench for the M register byte reader against a
// position-arithmetic byte model; parity checks only with X2050_MRD_PARITY_EN.
module tb_x2050_m_byte_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [31:0] words [0:64];
    bit tog = 1'b0;

    always #5 clk = ~clk;

    x2050_m_byte_reader_if bus ();
    x2050_m_byte_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic idle_inputs;
        bus.start = 1'b0;
        bus.mb = 2'd0;
        bus.len = 8'd0;
        bus.abort = 1'b0;
        bus.word_vld = 1'b0;
        bus.m_reg = 32'h0;
        bus.byte_rdy = 1'b0;
`ifdef X2050_MRD_PARITY_EN
        bus.m_par = 4'h0;
`endif
    endtask

    task automatic check_quiet(input string name);
        tests++;
        if (bus.busy !== 1'b0 || bus.byte_vld !== 1'b0 || bus.word_req !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL %s: busy=%b vld=%b req=%b done=%b, all must be 0", name, bus.busy, bus.byte_vld, bus.word_req, bus.done);
        end
    endtask

    // rdy_pct < 0 toggles ready every cycle
    task automatic run_transfer(input string name, input logic [1:0] mb, input logic [7:0] len,
                                input int rdy_pct, input int wv_pct, input bit fixed,
                                input logic [31:0] w0, input logic [31:0] w1, input bit bad_par);
        logic [7:0] got [$];
        logic [7:0] held, exp;
        int widx = 0, cyc = 0, p, nwords;
        bit holding = 1'b0, fin = 1'b0;
        for (int i = 0; i < 65; i++) words[i] = $urandom;
        if (fixed) begin
            words[0] = w0;
            words[1] = w1;
        end
        @(negedge clk);
        bus.mb = mb;
        bus.len = len;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!fin && cyc < 3000) begin
            if (bus.done) fin = 1'b1;
            if (holding && bus.byte_vld) begin
                tests++;
                if (bus.rd_byte !== held) begin
                    fails++;
                    $display("FAIL %s stable: got %h want %h", name, bus.rd_byte, held);
                end
            end
            holding = 1'b0;
            tog = ~tog;
            bus.byte_rdy = rdy_pct < 0 ? tog : ($urandom_range(99) < rdy_pct);
            if (bus.byte_vld) begin
`ifdef X2050_MRD_PARITY_EN
                tests++;
                if (bus.byte_par !== ~^bus.rd_byte) begin
                    fails++;
                    $display("FAIL %s byte_par: got %b want %b", name, bus.byte_par, ~^bus.rd_byte);
                end
`endif
                if (bus.byte_rdy) got.push_back(bus.rd_byte);
                else begin
                    holding = 1'b1;
                    held = bus.rd_byte;
                end
            end
            if (bus.word_req) begin
                bus.word_vld = $urandom_range(99) < wv_pct;
                bus.m_reg = bus.word_vld ? words[widx % 65] : $urandom;
`ifdef X2050_MRD_PARITY_EN
                for (int k = 0; k < 4; k++) bus.m_par[3-k] = ~^bus.m_reg[8*(3-k) +: 8];
                if (bad_par && widx == 0) bus.m_par[1] = ~bus.m_par[1];
`endif
                if (bus.word_vld) widx++;
            end else begin
                bus.word_vld = $urandom_range(3) == 0;
                bus.m_reg = $urandom;
            end
            bus.start = bus.busy && !fin ? 1'($urandom_range(1)) : 1'b0;
            bus.mb = 2'($urandom);
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL %s timeout: done not seen after %0d cycles", name, cyc);
        end
        tests++;
        if (got.size() != int'(len) + 1) begin
            fails++;
            $display("FAIL %s count: got %0d bytes want %0d", name, got.size(), int'(len) + 1);
        end
        for (int i = 0; i < got.size() && i <= int'(len); i++) begin
            p = int'(mb) + i;
            exp = words[p / 4] >> (8 * (3 - p % 4));
            tests++;
            if (got[i] !== exp) begin
                fails++;
                $display("FAIL %s byte[%0d]: got %h want %h", name, i, got[i], exp);
            end
        end
        nwords = (int'(mb) + int'(len)) / 4 + 1;
        tests++;
        if (widx != nwords) begin
            fails++;
            $display("FAIL %s word_reqs: got %0d want %0d", name, widx, nwords);
        end
`ifdef X2050_MRD_PARITY_EN
        tests++;
        if (bus.perr !== bad_par) begin
            fails++;
            $display("FAIL %s perr: got %b want %b", name, bus.perr, bad_par);
        end
`endif
        repeat (2) begin
            @(negedge clk);
            check_quiet({name, " after"});
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset_state");
        tests++;
        if (bus.rd_byte !== 8'h00) begin
            fails++;
            $display("FAIL reset_byte: got %h want 00", bus.rd_byte);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.mb = 2'd1;
        bus.len = 8'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.word_vld = 1'b1;
        bus.m_reg = 32'hCAFEF00D;
        @(negedge clk);
        bus.word_vld = 1'b0;
        tests++;
        if (bus.byte_vld !== 1'b1 || bus.rd_byte !== 8'hFE) begin
            fails++;
            $display("FAIL reset_pre: vld=%b byte=%h want 1/fe", bus.byte_vld, bus.rd_byte);
        end
        #1 rst_n = 1'b0;
        #1 check_quiet("reset_mid_send");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset_release");
    endtask

    task automatic test_single_word;
        run_transfer("mb1_len2", 2'd1, 8'd2, 100, 100, 1'b1, 32'h11223344, 32'h0, 1'b0);
    endtask

    task automatic test_word_cross;
        run_transfer("mb3_len1", 2'd3, 8'd1, 100, 100, 1'b1, 32'hAABBCCDD, 32'h55667788, 1'b0);
    endtask

    task automatic test_backpressure;
        run_transfer("toggle_rdy", 2'd2, 8'd9, -1, 100, 1'b0, 32'h0, 32'h0, 1'b0);
        run_transfer("random_rdy", 2'd0, 8'd13, 40, 60, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_abort;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_quiet("abort_idle");
        bus.mb = 2'd2;
        bus.len = 8'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.word_req !== 1'b1) begin
            fails++;
            $display("FAIL abort_wreq_req: got %b want 1", bus.word_req);
        end
        bus.abort = 1'b1;
        bus.word_vld = 1'b1;
        bus.m_reg = $urandom;
        @(negedge clk);
        idle_inputs();
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.byte_vld !== 1'b0) begin
            fails++;
            $display("FAIL abort_wreq: busy=%b done=%b vld=%b want 0/1/0", bus.busy, bus.done, bus.byte_vld);
        end
        @(negedge clk);
        check_quiet("abort_wreq_after");
        bus.mb = 2'd0;
        bus.len = 8'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.word_vld = 1'b1;
        bus.m_reg = 32'h01020304;
        @(negedge clk);
        bus.word_vld = 1'b0;
        tests++;
        if (bus.byte_vld !== 1'b1 || bus.rd_byte !== 8'h01) begin
            fails++;
            $display("FAIL abort_send_pre: vld=%b byte=%h want 1/01", bus.byte_vld, bus.rd_byte);
        end
        bus.byte_rdy = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        idle_inputs();
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.byte_vld !== 1'b0) begin
            fails++;
            $display("FAIL abort_send: busy=%b done=%b vld=%b want 0/1/0", bus.busy, bus.done, bus.byte_vld);
        end
        @(negedge clk);
        check_quiet("abort_send_after");
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++)
            run_transfer("random", 2'($urandom), 8'($urandom_range(40)), $urandom_range(100, 30),
                         $urandom_range(100, 30), 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_long;
`ifdef X2050_MRD_PARITY_EN
        run_transfer("len256_mb0", 2'd0, 8'd255, 100, 100, 1'b0, 32'h0, 32'h0, 1'b1);
`else
        run_transfer("len256_mb0", 2'd0, 8'd255, 100, 100, 1'b0, 32'h0, 32'h0, 1'b0);
`endif
        run_transfer("len256_mb3", 2'd3, 8'd255, 80, 70, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_word_cross();
        test_backpressure();
        test_abort();
        test_random();
        test_long();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
